// File: rtl/uart_tx_arbiter.sv
// Merges N_CH producer byte streams onto a single UartTx.
// Each channel has its own FIFO; one grant FSM drains them in RR or fixed order.
module uart_tx_arbiter #(
    parameter int N_CH      = 2,
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 8,
    parameter int PRIO_MODE = 0
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [N_CH-1:0]       req_en,
    input  logic [N_CH*WIDTH-1:0] req_data,
    output logic [N_CH-1:0]       req_full,
    output logic [N_CH-1:0]       req_overflow,
    output logic                  tx_start,
    output logic [WIDTH-1:0]      sdata,
    input  logic                  tx_busy,
    output logic                  idle
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mem_q [N_CH][DEPTH];
    logic [AW-1:0]    wr_q  [N_CH];
    logic [AW-1:0]    rd_q  [N_CH];
    logic [CW-1:0]    cnt_q [N_CH];
    logic [CW-1:0]    cnt_d [N_CH];
    logic [N_CH-1:0]  full_q, full_d;
    logic [N_CH-1:0]  ovf_q, ovf_d;
    logic [N_CH-1:0]  push, pop, nonempty;
    logic [LW-1:0]    last_q, last_d;
    logic [LW-1:0]    gnt, cand;
    logic             found;
    logic             ack_q, ack_d;
    logic [WIDTH-1:0] sdata_q, sdata_d;
    int               idx;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            push[i]     = req_en[i] & ~full_q[i];
            nonempty[i] = (cnt_q[i] != '0);
        end
    end

    // Grant candidate; only consumed by the FSM while in IDLE.
    always_comb begin
        gnt   = '0;
        cand  = '0;
        found = 1'b0;
        idx   = 0;
        if (PRIO_MODE != 0) begin
            for (int k = N_CH - 1; k >= 0; k--) begin
                if (nonempty[k]) begin
                    gnt   = LW'(k);
                    found = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                idx  = (int'(last_q) + 1 + k) % N_CH;
                cand = LW'(idx);
                if (!found && nonempty[cand]) begin
                    gnt   = cand;
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        sdata_d  = sdata_q;
        ack_d    = 1'b0;
        pop      = '0;
        tx_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found && !tx_busy) begin
                    pop[gnt] = 1'b1;
                    sdata_d  = mem_q[gnt][rd_q[gnt]];
                    last_d   = gnt;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                tx_start = 1'b1;
                state_d  = WAIT_ACK;
            end
            WAIT_ACK: begin
                // Give up waiting for busy after two cycles so a dead UART cannot hang us.
                if (tx_busy || ack_q) begin
                    state_d = WAIT_DONE;
                end else begin
                    ack_d = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (push[i] && !pop[i]) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (!push[i] && pop[i]) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
            full_d[i] = (cnt_d[i] == CW'(DEPTH));
            ovf_d[i]  = ovf_q[i] | (req_en[i] & full_q[i]);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            last_q  <= '0;
            sdata_q <= '0;
            ack_q   <= 1'b0;
            full_q  <= '0;
            ovf_q   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
                wr_q[i]  <= '0;
                rd_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sdata_q <= sdata_d;
            ack_q   <= ack_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                wr_q[i]  <= wr_q[i] + AW'(push[i]);
                rd_q[i]  <= rd_q[i] + AW'(pop[i]);
            end
        end
    end

    // Storage needs no reset; pointers and counts define what is valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_CH; i++) begin
            if (push[i]) begin
                mem_q[i][wr_q[i]] <= req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign req_full     = full_q;
    assign req_overflow = ovf_q;
    assign sdata        = sdata_q;
    assign idle         = (state_q == IDLE) && !(|nonempty);

endmodule
